digit_scan_ctrl: RTL and testbench
==================================

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 Parameter DIV, default 1000: clock cycles a digit stays active; legal range 1..65535.
REQ-002 Parameter GAP, default 4: blanking cycles between digits; 0 means no gap; legal range 0..255.
REQ-003 Parameter NDIG, default 8: digits scanned, indices 0..NDIG-1; legal range 1..8.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  scan enable; 0 forces IDLE.
REQ-007 wr_en  input  1  write strobe for the digit register file.
REQ-008 wr_addr  input  3  digit register index to write.
REQ-009 wr_data  input  4  nibble to store.
REQ-010 A2, A1, A0  output  1 each  current digit index (A2 = MSB); drives the 3-to-8 select decoder inputs.
REQ-011 digit  output  4  nibble of the currently indexed digit register.
REQ-012 blank  output  1  1 = display off; downstream gates the decoder outputs with it.
REQ-013 frame_done  output  1  one-cycle pulse when a full scan frame completes.

Function
REQ-014 Internal state: 8x4-bit register file, 3-bit idx, 16-bit cnt, FSM {IDLE, ACTIVE, GAPS}; all registered on clk.
REQ-015 {A2,A1,A0} SHALL equal idx in every state.
REQ-016 digit SHALL equal regfile[idx] combinationally from registered values.
REQ-017 blank SHALL be 1 in IDLE and GAPS, 0 in ACTIVE (decoded from registered state).
REQ-018 IDLE: cnt=0, idx=0; en=1 -> ACTIVE next cycle, cnt=0, idx=0.
REQ-019 ACTIVE: cnt increments each cycle; at cnt==DIV-1 -> cnt=0 and, if GAP>0, GAPS; if GAP==0, advance idx (REQ-021) and stay ACTIVE.
REQ-020 GAPS: idx held, cnt increments; at cnt==GAP-1 -> cnt=0, advance idx (REQ-021), ACTIVE.
REQ-021 Advance: idx = (idx==NDIG-1) ? 0 : idx+1; on wrap, frame_done=1 for exactly the following cycle, else 0.
REQ-022 Each digit SHALL be blank=0 for exactly DIV consecutive cycles per visit; one frame = NDIG*(DIV+GAP) cycles.
REQ-023 en=0 in any state SHALL force IDLE next cycle with idx=0, cnt=0, no frame_done pulse.
REQ-024 wr_en=1: regfile[wr_addr] = wr_data at the clock edge, in any state, independent of en; new value visible on digit from the next cycle if wr_addr==idx.
REQ-025 wr_addr >= NDIG SHALL still be written but SHALL never be displayed.
REQ-026 Write coincident with idx advance: register write and idx update both take effect at the same edge; no write is lost.
REQ-027 NDIG==1: idx stays 0; frame_done pulses once per DIV+GAP cycles.

Reset
REQ-028 rst_n=0 at a clock edge: state=IDLE, idx=0, cnt=0, regfile all 0, frame_done=0, hence A=000, digit=0, blank=1.
REQ-029 Reset SHALL dominate en and wr_en in the same cycle (write discarded).
REQ-030 Reset asserted mid-ACTIVE or mid-GAPS SHALL take effect at the next edge; no partial pulse on frame_done.

Verification (DIV=4, GAP=1, NDIG=8 unless noted)
REQ-031 Reset with en=1, wr_en=1 -> after release with en=0: A=000, digit=0, blank=1, regfile read back all 0.
REQ-032 Write regfile[i]=i+3 for i=0..7, raise en -> blank=0 for 4 cycles with A=000, digit=3; blank=1 for 1 cycle; A=001, digit=4; ... idx 7 then wrap to 0 with frame_done pulse; frame period 40 cycles.
REQ-033 GAP=0, NDIG=3 -> blank never 1 after start; idx sequence 0,1,2,0 each held 4 cycles; frame_done every 12 cycles.
REQ-034 During ACTIVE at idx=2 (second cycle), write wr_addr=2, wr_data=F -> digit changes to F next cycle; visit length still 4 cycles.
REQ-035 Drop en during GAPS at idx=5 -> next cycle IDLE, A=000, blank=1, frame_done=0; re-raise en -> scan restarts at idx 0 with full 4-cycle visit.
REQ-036 Assert rst_n=0 at cnt=2 of idx=7 -> next cycle A=000, digit=0, blank=1, no frame_done pulse.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// Multiplexed display scanner: cycles a digit index through NDIG positions, holding
// each visible for DIV cycles with GAP blanking cycles between digits.
module digit_scan_ctrl #(
    parameter int unsigned DIV  = 1000,
    parameter int unsigned GAP  = 4,
    parameter int unsigned NDIG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       A2,
    output logic       A1,
    output logic       A0,
    output logic [3:0] digit,
    output logic       blank,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAPS   = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [15:0] GAP_LAST = (GAP == 0) ? 16'd0 : 16'(GAP - 1);
    localparam logic [2:0]  IDX_LAST = 3'(NDIG - 1);
    localparam bit          HAS_GAP  = (GAP != 0);

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        frame_done_reg, frame_done_next;

    logic [2:0]  idx_adv;
    logic        idx_wrap;
    logic [31:0] regfile_flat;

    // Digit register file: one nibble cell per index, all eight always writable.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cell
            logic [3:0] cell_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cell_reg <= 4'd0;
                end else if (wr_en && (wr_addr == 3'(gi))) begin
                    cell_reg <= wr_data;
                end
            end

            assign regfile_flat[gi*4 +: 4] = cell_reg;
        end
    endgenerate

    assign idx_wrap = (idx_reg == IDX_LAST);
    assign idx_adv  = idx_wrap ? 3'd0 : 3'(idx_reg + 3'd1);

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                idx_next = 3'd0;
                cnt_next = 16'd0;
                state_next = ACTIVE;
            end
            ACTIVE: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = 16'd0;
                    if (HAS_GAP) begin
                        state_next = GAPS;
                    end else begin
                        idx_next        = idx_adv;
                        frame_done_next = idx_wrap;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            GAPS: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next        = 16'd0;
                    idx_next        = idx_adv;
                    frame_done_next = idx_wrap;
                    state_next      = ACTIVE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                cnt_next   = 16'd0;
            end
        endcase

        // Disable overrides everything, including a wrap that would have pulsed.
        if (!en) begin
            state_next      = IDLE;
            idx_next        = 3'd0;
            cnt_next        = 16'd0;
            frame_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= 3'd0;
            cnt_reg        <= 16'd0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign {A2, A1, A0} = idx_reg;
    assign digit        = regfile_flat[{idx_reg, 2'b00} +: 4];
    assign blank        = (state_reg != ACTIVE);
    assign frame_done   = frame_done_reg;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench: main scanner (DIV=4,GAP=1,NDIG=8), no-gap scanner (DIV=4,GAP=0,NDIG=3)
// and single-digit scanner (DIV=2,GAP=1,NDIG=1), all sharing the write bus and reset.
module tb_digit_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       en_b;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;

    logic       a2_a, a1_a, a0_a, blank_a, fd_a;
    logic [3:0] digit_a;
    logic       a2_b, a1_b, a0_b, blank_b, fd_b;
    logic [3:0] digit_b;
    logic       a2_c, a1_c, a0_c, blank_c, fd_c;
    logic [3:0] digit_c;

    int checks   = 0;
    int failures = 0;

    digit_scan_ctrl #(.DIV(4), .GAP(1), .NDIG(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .A2(a2_a), .A1(a1_a), .A0(a0_a), .digit(digit_a), .blank(blank_a), .frame_done(fd_a)
    );

    digit_scan_ctrl #(.DIV(4), .GAP(0), .NDIG(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .A2(a2_b), .A1(a1_b), .A0(a0_b), .digit(digit_b), .blank(blank_b), .frame_done(fd_b)
    );

    digit_scan_ctrl #(.DIV(2), .GAP(1), .NDIG(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .A2(a2_c), .A1(a1_c), .A0(a0_c), .digit(digit_c), .blank(blank_c), .frame_done(fd_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [2:0] a, input logic [3:0] d,
                            input logic b, input logic fd);
        check_value({tag, ".a.addr"},  32'({a2_a, a1_a, a0_a}), 32'(a));
        check_value({tag, ".a.digit"}, 32'(digit_a), 32'(d));
        check_value({tag, ".a.blank"}, 32'(blank_a), 32'(b));
        check_value({tag, ".a.fdone"}, 32'(fd_a), 32'(fd));
    endtask

    task automatic expect_b(input string tag, input logic [2:0] a, input logic [3:0] d,
                            input logic b, input logic fd);
        check_value({tag, ".b.addr"},  32'({a2_b, a1_b, a0_b}), 32'(a));
        check_value({tag, ".b.digit"}, 32'(digit_b), 32'(d));
        check_value({tag, ".b.blank"}, 32'(blank_b), 32'(b));
        check_value({tag, ".b.fdone"}, 32'(fd_b), 32'(fd));
    endtask

    task automatic expect_c(input string tag, input logic [2:0] a, input logic [3:0] d,
                            input logic b, input logic fd);
        check_value({tag, ".c.addr"},  32'({a2_c, a1_c, a0_c}), 32'(a));
        check_value({tag, ".c.digit"}, 32'(digit_c), 32'(d));
        check_value({tag, ".c.blank"}, 32'(blank_c), 32'(b));
        check_value({tag, ".c.fdone"}, 32'(fd_c), 32'(fd));
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] d;
        logic       fd;
        int         n;

        // Reset dominates en and a pending write to regfile[3]
        rst_n = 1'b0; en = 1'b1; en_b = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF;
        tick(); tick();
        expect_a("in_reset", 3'd0, 4'd0, 1'b1, 1'b0);
        expect_b("in_reset", 3'd0, 4'd0, 1'b1, 1'b0);

        rst_n = 1'b1; en = 1'b0; wr_en = 1'b0;
        tick();
        expect_a("idle_after_reset", 3'd0, 4'd0, 1'b1, 1'b0);

        // Scan one frame to read back every register as zero
        en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 5; c++) begin
                expect_a($sformatf("readback i%0d c%0d", i, c), 3'(i), 4'd0, (c == 4), 1'b0);
                tick();
            end
        end
        expect_a("readback_wrap", 3'd0, 4'd0, 1'b0, 1'b1);
        en = 1'b0;
        tick();
        expect_a("en_drop_no_pulse", 3'd0, 4'd0, 1'b1, 1'b0);

        // Load regfile[i] = i+3 while idle
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i + 3);
            tick();
        end
        wr_en = 1'b0;
        expect_a("idle_loaded", 3'd0, 4'd3, 1'b1, 1'b0);

        // Two full frames: 4 visible cycles + 1 gap per digit, 40 cycles per frame
        en = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                for (int c = 0; c < 5; c++) begin
                    fd = (f > 0) && (i == 0) && (c == 0);
                    expect_a($sformatf("scan f%0d i%0d c%0d", f, i, c), 3'(i), 4'(i + 3), (c == 4), fd);
                    tick();
                end
            end
        end
        expect_a("frame2_wrap", 3'd0, 4'd3, 1'b0, 1'b1);
        tick();
        expect_a("pulse_one_cycle", 3'd0, 4'd3, 1'b0, 1'b0);

        // Overwrite the displayed digit in the second cycle of idx 2
        repeat (10) tick();
        expect_a("idx2_c1", 3'd2, 4'd5, 1'b0, 1'b0);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hF;
        tick();
        wr_en = 1'b0;
        expect_a("live_write_c2", 3'd2, 4'hF, 1'b0, 1'b0);
        tick();
        expect_a("live_write_c3", 3'd2, 4'hF, 1'b0, 1'b0);
        tick();
        expect_a("live_write_gap", 3'd2, 4'hF, 1'b1, 1'b0);
        tick();
        expect_a("after_live_write", 3'd3, 4'd6, 1'b0, 1'b0);

        // Drop en during the gap after idx 5
        repeat (14) tick();
        expect_a("idx5_gap", 3'd5, 4'd8, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        expect_a("gap_disable", 3'd0, 4'd3, 1'b1, 1'b0);
        tick();
        expect_a("stay_idle", 3'd0, 4'd3, 1'b1, 1'b0);
        en = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            expect_a($sformatf("restart c%0d", c), 3'd0, 4'd3, 1'b0, 1'b0);
            tick();
        end
        expect_a("restart_gap", 3'd0, 4'd3, 1'b1, 1'b0);

        // Write regfile[1] on the same edge that advances to idx 1
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd9;
        tick();
        wr_en = 1'b0;
        expect_a("write_on_advance", 3'd1, 4'd9, 1'b0, 1'b0);

        // Reset at cnt=2 of idx 7
        repeat (32) tick();
        expect_a("idx7_c2", 3'd7, 4'd10, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_a("mid_scan_reset", 3'd0, 4'd0, 1'b1, 1'b0);
        rst_n = 1'b1; en = 1'b0;
        tick();
        expect_a("post_reset_idle", 3'd0, 4'd0, 1'b1, 1'b0);

        // No-gap and single-digit scanners; regfile[5] is loaded but never indexed
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_addr = (i == 3) ? 3'd5 : 3'(i);
            wr_data = (i == 3) ? 4'hE : 4'(i + 3);
            tick();
        end
        wr_en = 1'b0;
        en_b = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 4; c++) begin
                    n  = f * 12 + i * 4 + c;
                    fd = (f > 0) && (i == 0) && (c == 0);
                    expect_b($sformatf("nogap f%0d i%0d c%0d", f, i, c), 3'(i), 4'(i + 3), 1'b0, fd);
                    expect_c($sformatf("single n%0d", n), 3'd0, 4'd3, ((n % 3) == 2),
                             (n >= 3) && ((n % 3) == 0));
                    tick();
                end
            end
        end
        d = 4'd3;
        expect_b("nogap_wrap", 3'd0, d, 1'b0, 1'b1);
        expect_c("single_n36", 3'd0, d, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
